// File: rtl/main_control_fsm.sv
// Multi-cycle main control unit for the RV32I core: sequences fetch/decode/execute/
// memory/write-back, drives datapath selects and strobes, counts retired instructions.
module main_control_fsm #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        mem_ready,
  input  logic        br_taken,
  output logic [1:0]  ALUOp,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  result_src,
  output logic        pc_src,
  output logic        pc_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        illegal,
  output logic        bus_err,
  output logic [3:0]  state,
  output logic [31:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_I    = 4'd3,
    S_MEM_ADDR  = 4'd4,
    S_MEM_READ  = 4'd5,
    S_MEM_WB    = 4'd6,
    S_MEM_WRITE = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_TRAP      = 4'd11
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);
  localparam logic            WD_EN    = (TIMEOUT != 0) ? 1'b1 : 1'b0;

  state_e          state_r;
  state_e          next_state_s;
  logic [TO_W-1:0] wd_cnt_r;
  logic [TO_W-1:0] wd_cnt_nxt_s;
  logic            wait_s;
  logic            timeout_s;
  logic            retire_s;
  logic            illegal_r;
  logic            bus_err_r;
  logic [31:0]     instret_r;

  logic [1:0] aluop_s;
  logic [1:0] alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] result_src_s;
  logic       pc_src_s;
  logic       pc_write_s;
  logic       ir_write_s;
  logic       reg_write_s;
  logic       mem_req_s;
  logic       mem_we_s;
  logic       iord_s;

  function automatic state_e decode_op(input logic [6:0] op);
    case (op)
      OP_R:      decode_op = S_EXEC_R;
      OP_I:      decode_op = S_EXEC_I;
      OP_LOAD:   decode_op = S_MEM_ADDR;
      OP_STORE:  decode_op = S_MEM_ADDR;
      OP_BRANCH: decode_op = S_BRANCH;
      OP_JAL:    decode_op = S_JAL;
      default:   decode_op = S_TRAP;
    endcase
  endfunction

  function automatic logic is_wait(input state_e s);
    case (s)
      S_FETCH, S_MEM_READ, S_MEM_WRITE: is_wait = 1'b1;
      default:                          is_wait = 1'b0;
    endcase
  endfunction

  function automatic logic is_retire_src(input state_e s);
    case (s)
      S_ALU_WB, S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JAL: is_retire_src = 1'b1;
      default:                                        is_retire_src = 1'b0;
    endcase
  endfunction

  // Watchdog expiry wins only if memory is still not ready at the limit.
  assign wait_s    = is_wait(state_r);
  assign timeout_s = WD_EN & wait_s & ~mem_ready & (wd_cnt_r == TO_LIMIT);
  assign retire_s  = (next_state_s == S_FETCH) & is_retire_src(state_r);

  // State, watchdog, sticky flags and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= S_FETCH;
      wd_cnt_r  <= {TO_W{1'b0}};
      illegal_r <= 1'b0;
      bus_err_r <= 1'b0;
      instret_r <= 32'd0;
    end else begin
      state_r   <= next_state_s;
      wd_cnt_r  <= wd_cnt_nxt_s;
      illegal_r <= illegal_r | ((state_r == S_DECODE) & (next_state_s == S_TRAP));
      bus_err_r <= bus_err_r | timeout_s;
      if (retire_s) begin
        instret_r <= instret_r + 32'd1;
      end else begin
        instret_r <= instret_r;
      end
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_FETCH: begin
        if (timeout_s)      next_state_s = S_TRAP;
        else if (mem_ready) next_state_s = S_DECODE;
        else                next_state_s = S_FETCH;
      end
      S_DECODE:   next_state_s = decode_op(opcode);
      S_EXEC_R:   next_state_s = S_ALU_WB;
      S_EXEC_I:   next_state_s = S_ALU_WB;
      S_ALU_WB:   next_state_s = S_FETCH;
      S_MEM_ADDR: begin
        if (opcode == OP_LOAD) next_state_s = S_MEM_READ;
        else                   next_state_s = S_MEM_WRITE;
      end
      S_MEM_READ: begin
        if (timeout_s)      next_state_s = S_TRAP;
        else if (mem_ready) next_state_s = S_MEM_WB;
        else                next_state_s = S_MEM_READ;
      end
      S_MEM_WB:   next_state_s = S_FETCH;
      S_MEM_WRITE: begin
        if (timeout_s)      next_state_s = S_TRAP;
        else if (mem_ready) next_state_s = S_FETCH;
        else                next_state_s = S_MEM_WRITE;
      end
      S_BRANCH:   next_state_s = S_FETCH;
      S_JAL:      next_state_s = S_FETCH;
      S_TRAP:     next_state_s = S_TRAP;
      default:    next_state_s = S_TRAP;
    endcase
  end

  // Watchdog restarts on every state change and saturates at the limit.
  always_comb begin
    wd_cnt_nxt_s = wd_cnt_r;
    if (next_state_s != state_r) begin
      wd_cnt_nxt_s = {TO_W{1'b0}};
    end else if (wait_s && !mem_ready && (wd_cnt_r != TO_LIMIT)) begin
      wd_cnt_nxt_s = wd_cnt_r + TO_W'(1);
    end else begin
      wd_cnt_nxt_s = wd_cnt_r;
    end
  end

  // Moore output decode; FETCH and BRANCH strobes also follow mem_ready / br_taken.
  always_comb begin
    aluop_s      = 2'b00;
    alu_src_a_s  = 2'b00;
    alu_src_b_s  = 2'b00;
    result_src_s = 2'b00;
    pc_src_s     = 1'b0;
    pc_write_s   = 1'b0;
    ir_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    mem_req_s    = 1'b0;
    mem_we_s     = 1'b0;
    iord_s       = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_req_s = 1'b1;
        if (mem_ready) begin
          ir_write_s  = 1'b1;
          pc_write_s  = 1'b1;
          alu_src_b_s = 2'b10;
        end else begin
          ir_write_s  = 1'b0;
          pc_write_s  = 1'b0;
        end
      end
      S_DECODE: begin
        alu_src_a_s = 2'b01;
        alu_src_b_s = 2'b01;
      end
      S_EXEC_R: begin
        alu_src_a_s = 2'b10;
        aluop_s     = 2'b10;
      end
      S_EXEC_I: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        aluop_s     = 2'b10;
      end
      S_ALU_WB: reg_write_s = 1'b1;
      S_MEM_ADDR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
      end
      S_MEM_READ: begin
        mem_req_s = 1'b1;
        iord_s    = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_s  = 1'b1;
        result_src_s = 2'b01;
      end
      S_MEM_WRITE: begin
        mem_req_s = 1'b1;
        mem_we_s  = 1'b1;
        iord_s    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_s = 2'b10;
        aluop_s     = 2'b01;
        pc_src_s    = 1'b1;
        pc_write_s  = br_taken;
      end
      S_JAL: begin
        alu_src_a_s  = 2'b01;
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
        reg_write_s  = 1'b1;
        pc_src_s     = 1'b1;
        pc_write_s   = 1'b1;
      end
      S_TRAP:  aluop_s = 2'b00;
      default: aluop_s = 2'b00;
    endcase
  end

  // Strobes are held off combinationally while reset is asserted.
  assign pc_write  = pc_write_s  & rst_n;
  assign ir_write  = ir_write_s  & rst_n;
  assign reg_write = reg_write_s & rst_n;
  assign mem_req   = mem_req_s   & rst_n;
  assign mem_we    = mem_we_s    & rst_n;

  assign ALUOp      = aluop_s;
  assign alu_src_a  = alu_src_a_s;
  assign alu_src_b  = alu_src_b_s;
  assign result_src = result_src_s;
  assign pc_src     = pc_src_s;
  assign iord       = iord_s;
  assign illegal    = illegal_r;
  assign bus_err    = bus_err_r;
  assign state      = state_r;
  assign instret    = instret_r;

endmodule

// File: tb/tb_main_control_fsm.sv
// Self-checking bench for main_control_fsm: directed scenarios plus a randomized
// instruction stream checked against a phase-list model of each instruction class.
module tb_main_control_fsm;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic        mem_ready = 1'b0;
  logic        br_taken = 1'b0;
  logic [1:0]  ALUOp, alu_src_a, alu_src_b, result_src;
  logic        pc_src, pc_write, ir_write, reg_write, mem_req, mem_we, iord;
  logic        illegal, bus_err;
  logic [3:0]  state;
  logic [31:0] instret;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_instret = 0;

  typedef struct packed {
    logic [3:0] st;
    logic       rdy;
    logic       req;
    logic       rw;
    logic       pw;
  } step_t;
  step_t plan_q[$];

  main_control_fsm #(.TIMEOUT(16), .TO_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .br_taken(br_taken),
    .ALUOp(ALUOp), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .pc_src(pc_src), .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .illegal(illegal), .bus_err(bus_err),
    .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    exp_instret = 0;
  endtask

  task automatic plan_push(input logic [3:0] st, input logic rdy, input logic req,
                           input logic rw, input logic pw);
    step_t e;
    e.st = st; e.rdy = rdy; e.req = req; e.rw = rw; e.pw = pw;
    plan_q.push_back(e);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b1; opcode = OP_R;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({mem_req, ir_write, pc_write, reg_write, mem_we} !== 5'b00000)
        $display("FAIL reset_strobes: got %b expected 00000", {mem_req, ir_write, pc_write, reg_write, mem_we});
      else n_pass++;
      tick();
    end
    #1;
    n_checks++;
    if (instret !== 32'd0) $display("FAIL reset_instret: got %0d expected 0", instret);
    else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({state, mem_req} !== {4'd0, 1'b1})
      $display("FAIL reset_release: got state %0d mem_req %b expected 0 1", state, mem_req);
    else n_pass++;
    mem_ready = 1'b0;
  endtask

  task automatic test_alu_ops();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      logic [3:0] exs;
      exs = (k == 0) ? 4'd2 : 4'd3;
      opcode = (k == 0) ? OP_R : OP_I; mem_ready = 1'b1; br_taken = 1'($urandom);
      #1; n_checks++;
      if ({state, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, ALUOp} !== {4'd0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00})
        $display("FAIL alu_fetch: got st %0d irw %b pcw %b b %b", state, ir_write, pc_write, alu_src_b);
      else n_pass++;
      tick(); mem_ready = 1'($urandom);
      #1; n_checks++;
      if ({state, alu_src_a, alu_src_b, ALUOp} !== {4'd1, 2'b01, 2'b01, 2'b00})
        $display("FAIL alu_decode: got st %0d a %b b %b op %b", state, alu_src_a, alu_src_b, ALUOp);
      else n_pass++;
      tick(); mem_ready = 1'($urandom);
      #1; n_checks++;
      if ({state, ALUOp, alu_src_a, alu_src_b} !== {exs, 2'b10, 2'b10, (k == 0) ? 2'b00 : 2'b01})
        $display("FAIL alu_exec: got st %0d op %b a %b b %b expected st %0d", state, ALUOp, alu_src_a, alu_src_b, exs);
      else n_pass++;
      tick();
      #1; n_checks++;
      if ({state, reg_write, result_src} !== {4'd8, 1'b1, 2'b00})
        $display("FAIL alu_wb: got st %0d rw %b rs %b expected 8 1 00", state, reg_write, result_src);
      else n_pass++;
      tick(); exp_instret++;
      #1; n_checks++;
      if ({state, reg_write, instret} !== {4'd0, 1'b0, 32'(exp_instret)})
        $display("FAIL alu_retire: got st %0d rw %b instret %0d expected 0 0 %0d", state, reg_write, instret, exp_instret);
      else n_pass++;
    end
  endtask

  task automatic test_load_store();
    int ld_st[7] = '{0, 1, 4, 5, 5, 5, 6};
    int ld_rd[7] = '{1, 2, 2, 0, 0, 1, 2};
    int sd_st[6] = '{0, 1, 4, 7, 7, 7};
    int sd_rd[6] = '{1, 2, 2, 0, 0, 1};
    do_reset();
    opcode = OP_LOAD;
    for (int i = 0; i < 7; i++) begin
      mem_ready = (ld_rd[i] == 2) ? 1'($urandom) : 1'(ld_rd[i]);
      #1; n_checks++;
      if (state !== 4'(ld_st[i])) $display("FAIL load_state[%0d]: got %0d expected %0d", i, state, ld_st[i]);
      else n_pass++;
      n_checks++;
      if (i == 6) begin
        if ({reg_write, result_src} !== {1'b1, 2'b01}) $display("FAIL load_wb: got rw %b rs %b expected 1 01", reg_write, result_src);
        else n_pass++;
      end else if (ld_st[i] == 5) begin
        if ({mem_req, iord, mem_we, reg_write} !== 4'b1100) $display("FAIL load_req[%0d]: got %b expected 1100", i, {mem_req, iord, mem_we, reg_write});
        else n_pass++;
      end else begin
        if (reg_write !== 1'b0) $display("FAIL load_rw[%0d]: got %b expected 0", i, reg_write);
        else n_pass++;
      end
      tick();
    end
    #1; n_checks++;
    if ({state, instret} !== {4'd0, 32'd1}) $display("FAIL load_retire: got st %0d instret %0d expected 0 1", state, instret);
    else n_pass++;
    opcode = OP_STORE;
    for (int i = 0; i < 6; i++) begin
      mem_ready = (sd_rd[i] == 2) ? 1'($urandom) : 1'(sd_rd[i]);
      #1; n_checks++;
      if ({state, reg_write} !== {4'(sd_st[i]), 1'b0}) $display("FAIL store_state[%0d]: got st %0d rw %b expected %0d 0", i, state, reg_write, sd_st[i]);
      else n_pass++;
      if (i >= 3) begin
        n_checks++;
        if ({mem_req, mem_we, iord} !== 3'b111) $display("FAIL store_req[%0d]: got %b expected 111", i, {mem_req, mem_we, iord});
        else n_pass++;
      end else begin
        n_checks++;
        if (mem_we !== 1'b0) $display("FAIL store_we_early[%0d]: got %b expected 0", i, mem_we);
        else n_pass++;
      end
      tick();
    end
    #1; n_checks++;
    if ({state, instret} !== {4'd0, 32'd2}) $display("FAIL store_retire: got st %0d instret %0d expected 0 2", state, instret);
    else n_pass++;
  endtask

  task automatic test_branch();
    do_reset();
    opcode = OP_BRANCH;
    for (int k = 0; k < 2; k++) begin
      logic br;
      br = (k == 0);
      mem_ready = 1'b1; tick(); tick();
      br_taken = br;
      #1; n_checks++;
      if ({state, ALUOp, pc_src, pc_write} !== {4'd9, 2'b01, 1'b1, br})
        $display("FAIL branch[%0d]: got st %0d op %b pcs %b pcw %b expected 9 01 1 %b", k, state, ALUOp, pc_src, pc_write, br);
      else n_pass++;
      tick(); exp_instret++;
      #1; n_checks++;
      if ({state, instret} !== {4'd0, 32'(exp_instret)})
        $display("FAIL branch_retire[%0d]: got st %0d instret %0d expected 0 %0d", k, state, instret, exp_instret);
      else n_pass++;
    end
  endtask

  task automatic test_jal_illegal();
    do_reset();
    opcode = OP_JAL; mem_ready = 1'b1; tick(); tick();
    #1; n_checks++;
    if ({state, reg_write, result_src, pc_write, pc_src} !== {4'd10, 1'b1, 2'b10, 1'b1, 1'b1})
      $display("FAIL jal: got st %0d rw %b rs %b pcw %b pcs %b", state, reg_write, result_src, pc_write, pc_src);
    else n_pass++;
    tick();
    #1; n_checks++;
    if ({state, instret} !== {4'd0, 32'd1}) $display("FAIL jal_retire: got st %0d instret %0d expected 0 1", state, instret);
    else n_pass++;
    opcode = OP_ECALL; mem_ready = 1'b1; tick();
    #1; n_checks++;
    if ({state, illegal} !== {4'd1, 1'b0}) $display("FAIL illegal_decode: got st %0d ill %b expected 1 0", state, illegal);
    else n_pass++;
    tick();
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom);
      #1; n_checks++;
      if ({state, illegal, mem_req, bus_err} !== {4'd11, 1'b1, 1'b0, 1'b0})
        $display("FAIL illegal_hold[%0d]: got st %0d ill %b req %b berr %b", i, state, illegal, mem_req, bus_err);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (instret !== 32'd1) $display("FAIL illegal_instret: got %0d expected 1", instret);
    else n_pass++;
    rst_n = 1'b0; tick();
    #1; n_checks++;
    if ({state, illegal} !== {4'd0, 1'b0}) $display("FAIL illegal_clear: got st %0d ill %b expected 0 0", state, illegal);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_abort();
    do_reset();
    opcode = OP_R; mem_ready = 1'b1; tick(); tick(); tick();
    rst_n = 1'b0;
    #1; n_checks++;
    if (reg_write !== 1'b0) $display("FAIL abort_rw: got %b expected 0", reg_write);
    else n_pass++;
    tick(); rst_n = 1'b1; mem_ready = 1'b0;
    #1; n_checks++;
    if ({state, instret} !== {4'd0, 32'd0}) $display("FAIL abort_retire: got st %0d instret %0d expected 0 0", state, instret);
    else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    opcode = OP_R;
    for (int i = 0; i < 17; i++) begin
      mem_ready = 1'b0;
      #1; n_checks++;
      if ({state, mem_req, bus_err} !== {4'd0, 1'b1, 1'b0})
        $display("FAIL to_wait[%0d]: got st %0d req %b berr %b expected 0 1 0", i, state, mem_req, bus_err);
      else n_pass++;
      tick();
    end
    #1; n_checks++;
    if ({state, bus_err, mem_req} !== {4'd11, 1'b1, 1'b0})
      $display("FAIL to_trap: got st %0d berr %b req %b expected 11 1 0", state, bus_err, mem_req);
    else n_pass++;
    do_reset();
    repeat (16) begin mem_ready = 1'b0; tick(); end
    mem_ready = 1'b1;
    #1; n_checks++;
    if (state !== 4'd0) $display("FAIL to_edge_fetch: got %0d expected 0", state);
    else n_pass++;
    tick();
    #1; n_checks++;
    if ({state, bus_err} !== {4'd1, 1'b0}) $display("FAIL to_edge_win: got st %0d berr %b expected 1 0", state, bus_err);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [6:0] ops[6] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL};
    do_reset();
    for (int n = 0; n < 40; n++) begin
      int cls, fd, md;
      logic br;
      cls = $urandom_range(0, 5); fd = $urandom_range(0, 3); md = $urandom_range(0, 3);
      br = 1'($urandom);
      plan_q.delete();
      repeat (fd) plan_push(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      plan_push(4'd0, 1'b1, 1'b1, 1'b0, 1'b1);
      plan_push(4'd1, 1'($urandom), 1'b0, 1'b0, 1'b0);
      case (cls)
        0, 1: begin
          plan_push((cls == 0) ? 4'd2 : 4'd3, 1'($urandom), 1'b0, 1'b0, 1'b0);
          plan_push(4'd8, 1'($urandom), 1'b0, 1'b1, 1'b0);
        end
        2: begin
          plan_push(4'd4, 1'($urandom), 1'b0, 1'b0, 1'b0);
          repeat (md) plan_push(4'd5, 1'b0, 1'b1, 1'b0, 1'b0);
          plan_push(4'd5, 1'b1, 1'b1, 1'b0, 1'b0);
          plan_push(4'd6, 1'($urandom), 1'b0, 1'b1, 1'b0);
        end
        3: begin
          plan_push(4'd4, 1'($urandom), 1'b0, 1'b0, 1'b0);
          repeat (md) plan_push(4'd7, 1'b0, 1'b1, 1'b0, 1'b0);
          plan_push(4'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        4: plan_push(4'd9, 1'($urandom), 1'b0, 1'b0, br);
        default: plan_push(4'd10, 1'($urandom), 1'b0, 1'b1, 1'b1);
      endcase
      opcode = ops[cls];
      foreach (plan_q[j]) begin
        mem_ready = plan_q[j].rdy; br_taken = br;
        #1; n_checks++;
        if ({state, mem_req, reg_write, pc_write} !== {plan_q[j].st, plan_q[j].req, plan_q[j].rw, plan_q[j].pw})
          $display("FAIL rand[%0d.%0d] cls %0d: got st %0d req %b rw %b pcw %b expected %0d %b %b %b", n, j, cls,
                   state, mem_req, reg_write, pc_write, plan_q[j].st, plan_q[j].req, plan_q[j].rw, plan_q[j].pw);
        else n_pass++;
        tick();
      end
      exp_instret++;
      #1; n_checks++;
      if ({state, instret} !== {4'd0, 32'(exp_instret)})
        $display("FAIL rand_retire[%0d]: got st %0d instret %0d expected 0 %0d", n, state, instret, exp_instret);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_load_store();
    test_branch();
    test_jal_illegal();
    test_abort();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
